// File: rtl/clause_bin_loader_if.sv
// Clause-mover bus between bin_manager, the clause-bin RAM and the sat
// engine core's clause array. The loader drives the master side. Whatever
// sits around it (bin_manager, RAM, core) uses the slave side.
interface clause_bin_loader_if #(
   parameter int NUM_CLAUSES_A_BIN  = 8,
   parameter int WIDTH_BIN_ID       = 10,
   parameter int WIDTH_CLAUSES      = 16,
   parameter int ADDR_WIDTH_CLAUSES = 9
) ();

   // bin_manager command side
   logic                          start_load_i;
   logic                          start_update_i;
   logic [WIDTH_BIN_ID-1:0]       bin_num_i;
   logic                          busy_o;
   logic                          done_o;

   // clause-bin RAM side
   logic [ADDR_WIDTH_CLAUSES-1:0] ram_addr_c_o;
   logic                          ram_we_c_o;
   logic [WIDTH_CLAUSES-1:0]      ram_din_c_o;
   logic [WIDTH_CLAUSES-1:0]      ram_dout_c_i;

   // core clause-array side
   logic [NUM_CLAUSES_A_BIN-1:0]  wr_carray_o;
   logic [NUM_CLAUSES_A_BIN-1:0]  rd_carray_o;
   logic [WIDTH_CLAUSES-1:0]      clause_o;
   logic [WIDTH_CLAUSES-1:0]      clause_i;

   modport master (
      input  start_load_i,
      input  start_update_i,
      input  bin_num_i,
      output busy_o,
      output done_o,
      output ram_addr_c_o,
      output ram_we_c_o,
      output ram_din_c_o,
      input  ram_dout_c_i,
      output wr_carray_o,
      output rd_carray_o,
      output clause_o,
      input  clause_i
   );

   modport slave (
      output start_load_i,
      output start_update_i,
      output bin_num_i,
      input  busy_o,
      input  done_o,
      input  ram_addr_c_o,
      input  ram_we_c_o,
      input  ram_din_c_o,
      output ram_dout_c_i,
      input  wr_carray_o,
      input  rd_carray_o,
      input  clause_o,
      output clause_i
   );

endinterface

// File: rtl/clause_bin_loader.sv
// clause_bin_loader: moves one bin of clauses between the clause-bin RAM and
// the sat engine core's clause array.
//
// LOAD issues one RAM read per cycle. Each returned row is written into the
// core one cycle later, using a registered one-hot strobe. A drain cycle then
// collects the final RAM read.
//
// UPDATE selects one core row per cycle and writes it straight back to the
// matching RAM slot. The core answers combinationally on rd_carray_o.
module clause_bin_loader #(
   parameter int NUM_CLAUSES_A_BIN  = 8,
   parameter int NUM_VARS_A_BIN     = 8,
   parameter int WIDTH_BIN_ID       = 10,
   parameter int WIDTH_CLAUSES      = 16,
   parameter int ADDR_WIDTH_CLAUSES = 9
) (
   input  logic                   clk,
   input  logic                   rst,
   clause_bin_loader_if.master    bus
);

   // Row index width. The "last row" condition is kept as a separate
   // registered flag, so the counter never has to wrap.
   localparam int RW = (NUM_CLAUSES_A_BIN > 1) ? $clog2(NUM_CLAUSES_A_BIN) : 1;
   // Product width is wide enough that bin*N never overflows before truncation.
   localparam int PW = WIDTH_BIN_ID + 32;
   localparam logic [RW-1:0] LAST_ROW = RW'(NUM_CLAUSES_A_BIN - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_LOAD_DRAIN,
      S_UPDATE,
      S_DONE
   } state_t;

   state_t                         state_q;
   logic [WIDTH_BIN_ID-1:0]        bin_q;
   logic [RW-1:0]                  row_cnt_q;
   logic                           row_last_q;
   logic                           busy_q;
   logic                           done_q;
   logic [ADDR_WIDTH_CLAUSES-1:0]  addr_q;
   logic                           we_q;
   logic [NUM_CLAUSES_A_BIN-1:0]   wr_carray_q;
   logic [NUM_CLAUSES_A_BIN-1:0]   rd_carray_q;

   // RAM slot of a row: bin*N + row, wrapped to the RAM address space.
   function automatic logic [ADDR_WIDTH_CLAUSES-1:0] row_addr(
      input logic [WIDTH_BIN_ID-1:0] bin,
      input logic [RW-1:0]           row
   );
      logic [PW-1:0] full;
      full = PW'(bin) * PW'(NUM_CLAUSES_A_BIN) + PW'(row);
      return full[ADDR_WIDTH_CLAUSES-1:0];
   endfunction

   // One-hot core row select for a row index.
   function automatic logic [NUM_CLAUSES_A_BIN-1:0] row_onehot(input logic [RW-1:0] row);
      logic [NUM_CLAUSES_A_BIN-1:0] oh;
      oh      = '0;
      oh[row] = 1'b1;
      return oh;
   endfunction

   // Sequencer FSM. Every control and address output is a register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         bin_q       <= '0;
         row_cnt_q   <= '0;
         row_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         addr_q      <= '0;
         we_q        <= 1'b0;
         wr_carray_q <= '0;
         rd_carray_q <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // LOAD takes priority, so a simultaneous update request is dropped.
               if (bus.start_load_i) begin
                  state_q    <= S_LOAD;
                  bin_q      <= bus.bin_num_i;
                  row_cnt_q  <= '0;
                  row_last_q <= (NUM_CLAUSES_A_BIN == 1);
                  busy_q     <= 1'b1;
                  addr_q     <= row_addr(bus.bin_num_i, '0);
               end else if (bus.start_update_i) begin
                  state_q     <= S_UPDATE;
                  bin_q       <= bus.bin_num_i;
                  row_cnt_q   <= '0;
                  row_last_q  <= (NUM_CLAUSES_A_BIN == 1);
                  busy_q      <= 1'b1;
                  addr_q      <= row_addr(bus.bin_num_i, '0);
                  we_q        <= 1'b1;
                  rd_carray_q <= row_onehot('0);
               end
            end

            S_LOAD: begin
               // The row addressed now returns from RAM next cycle, together with its strobe.
               wr_carray_q <= row_onehot(row_cnt_q);
               if (row_last_q) begin
                  state_q    <= S_LOAD_DRAIN;
                  row_last_q <= 1'b0;
                  addr_q     <= '0;
               end else begin
                  row_cnt_q  <= row_cnt_q + RW'(1);
                  row_last_q <= ((row_cnt_q + RW'(1)) == LAST_ROW);
                  addr_q     <= row_addr(bin_q, row_cnt_q + RW'(1));
               end
            end

            S_LOAD_DRAIN: begin
               wr_carray_q <= '0;
               state_q     <= S_DONE;
               done_q      <= 1'b1;
            end

            S_UPDATE: begin
               if (row_last_q) begin
                  state_q     <= S_DONE;
                  done_q      <= 1'b1;
                  row_last_q  <= 1'b0;
                  we_q        <= 1'b0;
                  rd_carray_q <= '0;
                  addr_q      <= '0;
               end else begin
                  row_cnt_q   <= row_cnt_q + RW'(1);
                  row_last_q  <= ((row_cnt_q + RW'(1)) == LAST_ROW);
                  addr_q      <= row_addr(bin_q, row_cnt_q + RW'(1));
                  rd_carray_q <= row_onehot(row_cnt_q + RW'(1));
               end
            end

            S_DONE: begin
               state_q   <= S_IDLE;
               busy_q    <= 1'b0;
               row_cnt_q <= '0;
            end

            default: begin
               state_q     <= S_IDLE;
               busy_q      <= 1'b0;
               we_q        <= 1'b0;
               wr_carray_q <= '0;
               rd_carray_q <= '0;
               addr_q      <= '0;
            end
         endcase
      end
   end

   // Data passes through combinationally. It is gated to 0 whenever its strobe is idle.
   assign bus.clause_o     = (|wr_carray_q) ? bus.ram_dout_c_i : '0;
   assign bus.ram_din_c_o  = we_q ? bus.clause_i : '0;

   assign bus.busy_o       = busy_q;
   assign bus.done_o       = done_q;
   assign bus.ram_addr_c_o = addr_q;
   assign bus.ram_we_c_o   = we_q;
   assign bus.wr_carray_o  = wr_carray_q;
   assign bus.rd_carray_o  = rd_carray_q;

endmodule

// File: tb/tb_clause_bin_loader.sv
// Testbench for clause_bin_loader: a RAM and core model around the DUT, plus
// per-cycle expected output records kept in a queue.
module tb_clause_bin_loader;

   localparam int N  = 8;
   localparam int BW = 10;
   localparam int CW = 16;
   localparam int AW = 9;

   typedef struct packed {
      logic          busy;
      logic          done;
      logic [AW-1:0] addr;
      logic          we;
      logic [CW-1:0] din;
      logic [N-1:0]  wr;
      logic [N-1:0]  rd;
      logic [CW-1:0] clause;
   } obs_t;

   typedef struct {
      bit ld;
      bit up;
      int bin;
      int base;
      int upd_at;
      bit b2b;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   clause_bin_loader_if #(.NUM_CLAUSES_A_BIN(N), .WIDTH_BIN_ID(BW),
                          .WIDTH_CLAUSES(CW), .ADDR_WIDTH_CLAUSES(AW)) bus ();

   clause_bin_loader #(.NUM_CLAUSES_A_BIN(N), .NUM_VARS_A_BIN(8), .WIDTH_BIN_ID(BW),
                       .WIDTH_CLAUSES(CW), .ADDR_WIDTH_CLAUSES(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.master)
   );

   logic [CW-1:0] mem [512];
   logic [CW-1:0] ref_mem [512];
   logic [CW-1:0] core [N];
   logic          mem_ready = 1'b0;
   obs_t          exp_q [$];
   int            checks   = 0;
   int            failures = 0;

   // Clause RAM with synchronous read. It is filled with 0x1000+a on the first clock.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int a = 0; a < 512; a++) mem[a] <= 16'(32'h1000 + a);
         mem_ready <= 1'b1;
      end else begin
         if (bus.ram_we_c_o) mem[bus.ram_addr_c_o] <= bus.ram_din_c_o;
         bus.ram_dout_c_i <= mem[bus.ram_addr_c_o];
      end
   end

   // Core clause array. Row r always returns 0xA0+r.
   always_comb begin
      bus.clause_i = '0;
      for (int r = 0; r < N; r++)
         if (bus.rd_carray_o == N'(1 << r)) bus.clause_i = 16'(16'hA0 + r);
   end

   function automatic obs_t sample();
      obs_t o;
      o.busy   = bus.busy_o;
      o.done   = bus.done_o;
      o.addr   = bus.ram_addr_c_o;
      o.we     = bus.ram_we_c_o;
      o.din    = bus.ram_din_c_o;
      o.wr     = bus.wr_carray_o;
      o.rd     = bus.rd_carray_o;
      o.clause = bus.clause_o;
      return o;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_obs(input string name, input obs_t exp);
      obs_t act;
      act = sample();
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got busy=%0b done=%0b addr=%0d we=%0b din=%h wr=%h rd=%h clause=%h | want busy=%0b done=%0b addr=%0d we=%0b din=%h wr=%h rd=%h clause=%h",
                  name, act.busy, act.done, act.addr, act.we, act.din, act.wr, act.rd, act.clause,
                  exp.busy, exp.done, exp.addr, exp.we, exp.din, exp.wr, exp.rd, exp.clause);
      end
   endtask

   task automatic pop_check(input string name);
      if (exp_q.size() == 0) begin
         checks++;
         failures++;
         $display("FAIL %s got output cycle with no expected record, want queued record", name);
      end else begin
         check_obs(name, exp_q.pop_front());
      end
   endtask

   // Reference model: queues the expected outputs for cycles 1..limit of an operation.
   task automatic push_op(input bit ld, input int base, input int limit);
      obs_t o;
      int   a;
      int   last;
      last = ld ? N + 3 : N + 2;
      for (int k = 1; k <= last && k <= limit; k++) begin
         o = '0;
         if (ld) begin
            o.busy = (k <= N + 2);
            o.done = (k == N + 2);
            if (k <= N) o.addr = AW'((base + k - 1) % 512);
            if (k >= 2 && k <= N + 1) begin
               o.wr     = N'(1 << (k - 2));
               o.clause = ref_mem[(base + k - 2) % 512];
            end
         end else begin
            o.busy = (k <= N + 1);
            o.done = (k == N + 1);
            if (k <= N) begin
               a          = (base + k - 1) % 512;
               o.addr     = AW'(a);
               o.we       = 1'b1;
               o.din      = core[k - 1];
               o.rd       = N'(1 << (k - 1));
               ref_mem[a] = core[k - 1];
            end
         end
         exp_q.push_back(o);
      end
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int n;
      bus.start_load_i   = v.ld;
      bus.start_update_i = v.up;
      bus.bin_num_i      = BW'(v.bin);
      push_op(v.ld, v.base, 99);
      n = exp_q.size();
      for (int c = 1; c <= n; c++) begin
         tick();
         pop_check($sformatf("v%0d_cyc%0d", idx, c));
         bus.start_load_i   = 1'b0;
         bus.start_update_i = (c == v.upd_at);
         bus.bin_num_i      = BW'($urandom_range(0, 1023));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout, want $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vecs [7];
      vec_t fresh;
      logic [CW-1:0] want;

      for (int a = 0; a < 512; a++) ref_mem[a] = 16'(32'h1000 + a);
      for (int r = 0; r < N; r++)   core[r]    = 16'(16'hA0 + r);

      //         ld  up  bin base upd_at b2b
      vecs[0] = '{1, 0,  2,  16,  0, 0};  // plain LOAD
      vecs[1] = '{0, 1,  1,   8,  0, 0};  // plain UPDATE
      vecs[2] = '{1, 1,  3,  24,  0, 0};  // both starts: LOAD wins
      vecs[3] = '{1, 0,  5,  40,  4, 0};  // update pulse mid-LOAD ignored
      vecs[4] = '{1, 0, 63, 504,  0, 0};  // top of RAM
      vecs[5] = '{1, 0, 64,   0,  0, 1};  // base wraps mod 512, back-to-back
      vecs[6] = '{1, 0,  1,   8,  0, 1};  // back-to-back, reloads updated bin 1

      bus.start_load_i   = 1'b0;
      bus.start_update_i = 1'b0;
      bus.bin_num_i      = '0;

      repeat (3) tick();
      check_obs("reset_state", '0);
      rst = 1'b1;
      tick();
      check_obs("idle_after_reset", '0);

      for (int i = 0; i < 7; i++) begin
         if (!vecs[i].b2b) begin
            tick();
            tick();
         end
         run_vec(vecs[i], i);
      end

      // Reset in cycle 5 of an UPDATE of bin 0: only rows 0..3 reach the RAM.
      tick();
      tick();
      bus.start_update_i = 1'b1;
      bus.bin_num_i      = '0;
      push_op(1'b0, 0, 4);
      for (int c = 1; c <= 4; c++) begin
         tick();
         pop_check($sformatf("abort_cyc%0d", c));
         bus.start_update_i = 1'b0;
      end
      tick();
      #1 rst = 1'b0;
      #1 check_obs("rst_mid_update", '0);
      tick();
      check_obs("rst_held", '0);
      rst = 1'b1;
      for (int a = 0; a < 8; a++) begin
         want = (a < 4) ? 16'(16'hA0 + a) : 16'(32'h1000 + a);
         checks++;
         if (mem[a] !== want) begin
            failures++;
            $display("FAIL ram_after_abort[%0d] got %h want %h", a, mem[a], want);
         end
      end
      for (int c = 0; c < 3; c++) begin
         tick();
         check_obs($sformatf("post_abort_idle%0d", c), '0);
      end
      fresh = '{1, 0, 0, 0, 0, 0};
      run_vec(fresh, 7);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL leftover_expected got %0d records want 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
